pll_mdrp_ctrl: RTL

PLL_MDRP_CTRL -- requirements
Module: pll_mdrp_ctrl

---
 rtl/pll_mdrp_ctrl_if.sv | 30 +++
 rtl/pll_mdrp_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_mdrp_ctrl_if.sv
// Command, response and PLL dynamic-reconfiguration (MDRP) signals of pll_mdrp_ctrl.
// The controller connects through the slave modport; the command source uses master.
interface pll_mdrp_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       mdclk;
    logic [1:0] mdopc;
    logic       mdainc;
    logic [7:0] mdwdi;
    logic [7:0] mdrdo;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, mdrdo,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output mdclk, mdopc, mdainc, mdwdi
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, mdrdo,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  mdclk, mdopc, mdainc, mdwdi
    );
endinterface

// File: rtl/pll_mdrp_ctrl.sv
// Sequences single PLL MDRP accesses: optional address clear, increment seek, op, read wait.
// Define PLL_MDRP_VERIFY_EN to read back every write and flag a mismatch on rsp_err.
module pll_mdrp_ctrl #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic           clk,
    input  logic           reset,
    pll_mdrp_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, CLR = 3'd1, SEEK = 3'd2, OP = 3'd3, WAIT = 3'd4, RESP = 3'd5
    } state_t;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);
    localparam logic [1:0] OPC_NOP  = 2'b00;
    localparam logic [1:0] OPC_WR   = 2'b01;
    localparam logic [1:0] OPC_RD   = 2'b10;
    localparam logic [1:0] OPC_CLR  = 2'b11;

    state_t     r_state, w_state;
    logic [3:0] r_div;
    logic       r_mdclk, w_fall, w_rise;
    logic [1:0] r_mdopc, w_mdopc;
    logic       r_mdainc, w_mdainc;
    logic [7:0] r_mdwdi, w_mdwdi;
    logic       r_rsp_valid, w_rsp_valid;
    logic [7:0] r_rsp_rdata, w_rsp_rdata;
    logic       r_busy, r_ready;
    logic [7:0] r_cur_addr, w_cur_addr, w_seek_addr;
    logic       r_addr_ok, w_addr_ok;
    logic       r_clr_on, w_clr_on;
    logic [7:0] r_tgt, w_tgt, r_wdata, w_wdata;
    logic       r_write, w_write;
    logic [2:0] r_wcnt, w_wcnt;
`ifdef PLL_MDRP_VERIFY_EN
    logic       r_rsp_err, w_rsp_err;
    logic       r_vfy, w_vfy;
    logic       r_chk, w_chk;
`endif

    // mdclk slot timer: CLK_DIV cycles low, then CLK_DIV cycles high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div   <= 4'd0;
            r_mdclk <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div   <= 4'd0;
            r_mdclk <= ~r_mdclk;
        end else begin
            r_div   <= r_div + 4'd1;
        end
    end

    assign w_fall = r_mdclk & (r_div == DIV_LAST);
    assign w_rise = ~r_mdclk & (r_div == DIV_LAST);

    // next-state and next-output logic; slot outputs only move on an mdclk fall
    always_comb begin
        w_state     = r_state;
        w_mdopc     = w_fall ? OPC_NOP : r_mdopc;
        w_mdainc    = w_fall ? 1'b0 : r_mdainc;
        w_mdwdi     = w_fall ? 8'h00 : r_mdwdi;
        w_rsp_valid = 1'b0;
        w_rsp_rdata = r_rsp_rdata;
        w_cur_addr  = r_cur_addr;
        w_addr_ok   = r_addr_ok;
        w_clr_on    = r_clr_on;
        w_tgt       = r_tgt;
        w_wdata     = r_wdata;
        w_write     = r_write;
        w_wcnt      = (w_fall && (r_wcnt != 3'd0)) ? (r_wcnt - 3'd1) : r_wcnt;
        w_seek_addr = (r_state == CLR) ? 8'h00 : r_cur_addr;
`ifdef PLL_MDRP_VERIFY_EN
        w_rsp_err   = r_rsp_err;
        w_vfy       = r_vfy;
        w_chk       = r_chk;
`endif
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid && r_ready) begin
                    w_tgt    = bus.cmd_addr;
                    w_wdata  = bus.cmd_wdata;
                    w_write  = bus.cmd_write;
                    w_clr_on = 1'b0;
                    // an unknown PLL address (after reset) always forces a clear
                    w_state  = (!r_addr_ok || (bus.cmd_addr < r_cur_addr)) ? CLR : SEEK;
`ifdef PLL_MDRP_VERIFY_EN
                    w_vfy    = 1'b0;
                    w_chk    = 1'b0;
`endif
                end else begin
                    w_state = IDLE;
                end
            end
            CLR, SEEK: begin
                if (w_fall && (r_state == CLR) && !r_clr_on) begin
                    w_mdopc  = OPC_CLR;
                    w_clr_on = 1'b1;
                end else if (w_fall) begin
                    w_clr_on  = 1'b0;
                    w_addr_ok = 1'b1;
                    if (w_seek_addr != r_tgt) begin
                        w_mdainc   = 1'b1;
                        w_cur_addr = w_seek_addr + 8'd1;
                        w_state    = SEEK;
                    end else begin
                        w_mdopc    = r_write ? OPC_WR : OPC_RD;
                        w_mdwdi    = r_write ? r_wdata : 8'h00;
                        w_cur_addr = w_seek_addr;
                        w_state    = OP;
                    end
                end else begin
                    w_state = r_state;
                end
            end
            OP: begin
                if (w_fall) begin
                    w_wcnt = LAT_LAST;
                    if (!r_write) begin
                        w_state = WAIT;
                    end else begin
`ifdef PLL_MDRP_VERIFY_EN
                        w_vfy   = 1'b1;
                        w_chk   = 1'b1;
                        w_write = 1'b0;
                        w_state = WAIT;
`else
                        w_rsp_valid = 1'b1;
                        w_rsp_rdata = 8'h00;
                        w_state     = RESP;
`endif
                    end
                end else begin
                    w_state = OP;
                end
            end
            WAIT: begin
`ifdef PLL_MDRP_VERIFY_EN
                if (r_vfy) begin
                    if (w_fall && (r_wcnt == 3'd0)) begin
                        w_mdopc = OPC_RD;
                        w_vfy   = 1'b0;
                        w_state = OP;
                    end else begin
                        w_state = WAIT;
                    end
                end else
`endif
                if (w_rise && (r_wcnt == 3'd0)) begin
                    w_rsp_rdata = bus.mdrdo;
                    w_rsp_valid = 1'b1;
                    w_state     = RESP;
`ifdef PLL_MDRP_VERIFY_EN
                    w_rsp_err   = r_chk && (bus.mdrdo != r_wdata);
`endif
                end else begin
                    w_state = WAIT;
                end
            end
            RESP:    w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end

    // state, address mirror and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mdopc     <= OPC_NOP;
            r_mdainc    <= 1'b0;
            r_mdwdi     <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
            r_cur_addr  <= 8'hFF;
            r_addr_ok   <= 1'b0;
            r_clr_on    <= 1'b0;
            r_tgt       <= 8'h00;
            r_wdata     <= 8'h00;
            r_write     <= 1'b0;
            r_wcnt      <= 3'd0;
`ifdef PLL_MDRP_VERIFY_EN
            r_rsp_err   <= 1'b0;
            r_vfy       <= 1'b0;
            r_chk       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state;
            r_mdopc     <= w_mdopc;
            r_mdainc    <= w_mdainc;
            r_mdwdi     <= w_mdwdi;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_busy      <= (w_state != IDLE);
            r_ready     <= (w_state == IDLE);
            r_cur_addr  <= w_cur_addr;
            r_addr_ok   <= w_addr_ok;
            r_clr_on    <= w_clr_on;
            r_tgt       <= w_tgt;
            r_wdata     <= w_wdata;
            r_write     <= w_write;
            r_wcnt      <= w_wcnt;
`ifdef PLL_MDRP_VERIFY_EN
            r_rsp_err   <= w_rsp_err;
            r_vfy       <= w_vfy;
            r_chk       <= w_chk;
`endif
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.mdclk     = r_mdclk;
    assign bus.mdopc     = r_mdopc;
    assign bus.mdainc    = r_mdainc;
    assign bus.mdwdi     = r_mdwdi;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
`ifdef PLL_MDRP_VERIFY_EN
    assign bus.rsp_err   = r_rsp_err;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule
